// File: rtl/rom_streamer_pkg.sv
// rom_streamer_pkg: shared types and constants for the ROM streamer.
//   state_t        FSM encoding (IDLE, RUN, DRAIN)
//   FIFO_DEPTH     output buffer depth
//   OCC_W          width of the FIFO occupancy count
//   ISSUE_CREDITS  max words buffered plus reads in flight
package rom_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned FIFO_DEPTH    = 2;
  localparam int unsigned OCC_W         = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ISSUE_CREDITS = FIFO_DEPTH;

endpackage

// File: rtl/rom_streamer_fifo.sv
// stream_fifo2: 2-entry valid/ready FIFO with a registered head.
//   clk, reset      clock, synchronous active-high reset
//   flush           drop all entries (wins over push/pop)
//   push, push_data write a word
//   pop             head consumed (must only be asserted with out_valid)
//   out_data        head word, held stable until popped
//   out_valid       head valid
//   occupancy       number of stored words
module stream_fifo2
  import rom_streamer_pkg::*;
#(
  parameter int unsigned DATA_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [OCC_W-1:0]  occupancy
);

  logic [DATA_W-1:0] tail_data;
  logic              tail_valid;

  // Tail is only ever valid while the head is valid.
  assign occupancy = OCC_W'(out_valid) + OCC_W'(tail_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      tail_data  <= '0;
      tail_valid <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      tail_valid <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!out_valid) begin
            out_data  <= push_data;
            out_valid <= 1'b1;
          end else begin
            tail_data  <= push_data;
            tail_valid <= 1'b1;
          end
        end
        2'b01: begin
          if (tail_valid) out_data <= tail_data;
          out_valid  <= tail_valid;
          tail_valid <= 1'b0;
        end
        // Simultaneous push/pop: occupancy unchanged, queue shifts by one.
        2'b11: begin
          if (tail_valid) begin
            out_data  <= tail_data;
            tail_data <= push_data;
          end else begin
            out_data <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rom_streamer.sv
// rom_streamer: walks an address range of a synchronous ROM (1-cycle read
// latency) and streams the words downstream on a valid/ready handshake.
// Optional feature macro: ROM_STREAMER_LOOP_EN adds the 'loop' input; a run
// launched with loop=1 repeats the range until aborted.
//   clk, reset             clock, synchronous active-high reset
//   start, abort           launch (IDLE only) / terminate a run
//   loop                   (ROM_STREAMER_LOOP_EN only) repeat range
//   first_addr, last_addr  inclusive range, captured on accepted start
//   rom_addr, rom_data     ROM address (registered) and read data
//   out_data, out_valid    streamed word and its valid
//   out_ready              downstream ready
//   busy, done             run in progress / one-cycle completion pulse
module rom_streamer
  import rom_streamer_pkg::*;
#(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
`ifdef ROM_STREAMER_LOOP_EN
  input  logic              loop,
`endif
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_t            state;
  logic              pending;
  logic [CNT_W-1:0]  remaining;
  logic [OCC_W-1:0]  occupancy;
  logic [ADDR_W-1:0] span_c;
  logic [CNT_W-1:0]  count_c;
  logic              pop_c;
  logic              issue_c;
  logic              last_pop_c;

`ifdef ROM_STREAMER_LOOP_EN
  logic              loop_q;
  logic [ADDR_W-1:0] first_q;
  logic [CNT_W-1:0]  count_q;
`endif

  // Word count: modulo span plus one (full ROM when last == first-1).
  assign span_c  = last_addr - first_addr;
  assign count_c = CNT_W'(span_c) + CNT_W'(1);

  assign pop_c = out_valid & out_ready;

  // Issue only while credits remain; a same-cycle pop frees one.
  assign issue_c = (state == RUN) && !abort &&
                   (((3'(occupancy) + 3'(pending)) < 3'(ISSUE_CREDITS)) || pop_c);

  // Final handshake: nothing left in flight and only the last word buffered.
  assign last_pop_c = (state == DRAIN) && !pending &&
                      (occupancy == OCC_W'(1)) && pop_c;

  stream_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (abort),
    .push      (pending),
    .push_data (rom_data),
    .pop       (pop_c),
    .out_data  (out_data),
    .out_valid (out_valid),
    .occupancy (occupancy)
  );

  // FSM, address counter, remaining-word counter and pending-read bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rom_addr  <= '0;
      pending   <= 1'b0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef ROM_STREAMER_LOOP_EN
      loop_q    <= 1'b0;
      first_q   <= '0;
      count_q   <= '0;
`endif
    end else begin
      done    <= 1'b0;
      pending <= issue_c;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state     <= RUN;
            busy      <= 1'b1;
            rom_addr  <= first_addr;
            remaining <= count_c;
`ifdef ROM_STREAMER_LOOP_EN
            loop_q    <= loop;
            first_q   <= first_addr;
            count_q   <= count_c;
`endif
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (issue_c) begin
            if (remaining == CNT_W'(1)) begin
`ifdef ROM_STREAMER_LOOP_EN
              if (loop_q) begin
                rom_addr  <= first_q;
                remaining <= count_q;
              end else
`endif
              begin
                rom_addr  <= rom_addr + ADDR_W'(1);
                remaining <= '0;
                state     <= DRAIN;
              end
            end else begin
              rom_addr  <= rom_addr + ADDR_W'(1);
              remaining <= remaining - CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (last_pop_c) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
